memory_tile_reader: RTL and testbench

- Read-side client of the image Memory block: walks a rectangular tile (base, width, height, row stride) and issues one read address per pixel on a single memory read port.
- Absorbs the memory's fixed 1-cycle read latency and streams pixels out on a valid/ready interface with a last-beat marker.
- Sits between the image memory and the convolution datapath (systolic/DSP feeders).

---
 rtl/tile_reader_pkg.sv | 21 ++
 rtl/tile_reader_fifo2.sv | 49 ++++
 rtl/memory_tile_reader.sv | 170 +++++++++++++++++
 tb/tb_memory_tile_reader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_reader_pkg.sv
// Shared types and defaults for the memory tile reader: FSM state encoding,
// width defaults and the output buffer entry layout.
package tile_reader_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 18;
    localparam int DIM_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } tile_state_e;

    // Buffer entry is {last, zero, data}; the flag offsets are relative to DATA_W.
    localparam int ENTRY_FLAGS = 2;
    localparam int LAST_OFS    = 1;
    localparam int ZERO_OFS    = 0;

endpackage

// File: rtl/tile_reader_fifo2.sv
// Two-entry FIFO holding {last, zero, data} buffer entries, with an occupancy
// count so the issuing logic can budget its memory reads.
module tile_reader_fifo2
    import tile_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_W+ENTRY_FLAGS-1:0] din,
    input  logic                          pop,
    output logic [DATA_W+ENTRY_FLAGS-1:0] head,
    output logic [1:0]                    count
);

    logic [DATA_W+ENTRY_FLAGS-1:0] mem_q [2];
    logic                          wr_q;
    logic                          rd_q;
    logic [1:0]                    count_q;

    // The caller never pushes into a full buffer nor pops an empty one.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= din;
                wr_q        <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head  = mem_q[rd_q];
    assign count = count_q;

endmodule

// File: rtl/memory_tile_reader.sv
// Walks a rectangular tile in raster order, issuing one memory read per pixel and
// streaming the returned pixels out. Optional border padding: TILE_READER_ZERO_PAD_EN.
module memory_tile_reader
    import tile_reader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DIM_W  = DIM_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DIM_W-1:0]  tile_w,
    input  logic [DIM_W-1:0]  tile_h,
    input  logic [DIM_W-1:0]  row_stride,
`ifdef TILE_READER_ZERO_PAD_EN
    input  logic [1:0]        pad,
`endif
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_read_addr,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output tile_state_e       fsm_state
);

    localparam int CNT_W = DIM_W + 1;
    localparam int EW    = DATA_W + ENTRY_FLAGS;

    tile_state_e       state_q, state_d;
    logic [DIM_W-1:0]  w_q, h_q, stride_q;
    logic [ADDR_W-1:0] row_base_q, last_addr_q, cur_addr;
    logic [CNT_W-1:0]  col_q, row_q, ext_w, ext_h, col_off;
    logic              inflight_q, inflight_last_q, inflight_zero_q;
    logic              accept, issue, mem_read, pop, credit_ok;
    logic              at_row_end, at_last, border, row_interior;
    logic [2:0]        occupancy;
    logic [1:0]        buf_count;
    logic [EW-1:0]     buf_head, buf_din;

`ifdef TILE_READER_ZERO_PAD_EN
    logic [1:0]       pad_q;
    logic [CNT_W-1:0] pad_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            pad_q <= 2'd0;
        end else if (accept) begin
            pad_q <= pad;
        end
    end

    // The padded frame is walked as one raster; interior positions map back to memory.
    always_comb begin
        pad_ext      = CNT_W'(pad_q);
        ext_w        = CNT_W'(w_q) + (pad_ext << 1);
        ext_h        = CNT_W'(h_q) + (pad_ext << 1);
        row_interior = (row_q >= pad_ext) && (row_q < pad_ext + CNT_W'(h_q));
        border       = !row_interior || (col_q < pad_ext) || (col_q >= pad_ext + CNT_W'(w_q));
        col_off      = col_q - pad_ext;
    end
`else
    always_comb begin
        ext_w        = CNT_W'(w_q);
        ext_h        = CNT_W'(h_q);
        row_interior = 1'b1;
        border       = 1'b0;
        col_off      = col_q;
    end
`endif

    // out_valid/out_ready: a beat moves on a rising edge where both are high. out_valid
    // comes only from buffer occupancy, and the head entry holds until it is popped.
    always_comb begin
        out_valid  = (buf_count != 2'd0);
        pop        = out_valid && out_ready;
        occupancy  = 3'(buf_count) + 3'(inflight_q) - 3'(pop);
        credit_ok  = (occupancy < 3'd2);
        accept     = (state_q == ST_IDLE) && start;
        issue      = (state_q == ST_ISSUE) && credit_ok;
        mem_read   = issue && !border;
        at_row_end = (col_q == ext_w - CNT_W'(1));
        at_last    = at_row_end && (row_q == ext_h - CNT_W'(1));
        cur_addr   = row_base_q + ADDR_W'(col_off);
        mem_read_addr = mem_read ? cur_addr : last_addr_q;
        out_last   = out_valid && buf_head[DATA_W+LAST_OFS];
        out_data   = buf_head[DATA_W+ZERO_OFS] ? '0 : buf_head[DATA_W-1:0];
        buf_din    = {inflight_last_q, inflight_zero_q, mem_read_data};
        busy       = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
        done       = (state_q == ST_DONE);
        fsm_state  = state_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (tile_w == '0 || tile_h == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue && at_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Leave as the final beat is popped so done follows that handshake directly.
                if (!inflight_q && (buf_count == 2'd0 || (buf_count == 2'd1 && pop))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            w_q             <= '0;
            h_q             <= '0;
            stride_q        <= '0;
            row_base_q      <= '0;
            col_q           <= '0;
            row_q           <= '0;
            last_addr_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            inflight_zero_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            inflight_q      <= issue;
            inflight_last_q <= issue && at_last;
            inflight_zero_q <= issue && border;
            if (mem_read) last_addr_q <= cur_addr;
            if (accept) begin
                w_q        <= tile_w;
                h_q        <= tile_h;
                stride_q   <= row_stride;
                row_base_q <= base_addr;
                col_q      <= '0;
                row_q      <= '0;
            end else if (issue) begin
                if (at_row_end) begin
                    col_q <= '0;
                    row_q <= row_q + CNT_W'(1);
                    if (row_interior) row_base_q <= row_base_q + ADDR_W'(stride_q);
                end else begin
                    col_q <= col_q + CNT_W'(1);
                end
            end
        end
    end

    tile_reader_fifo2 #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .din   (buf_din),
        .pop   (pop),
        .head  (buf_head),
        .count (buf_count)
    );

endmodule

// File: tb/tb_memory_tile_reader.sv
// Directed and randomized tiles against a raster/address-arithmetic reference model
// and a behavioural memory with word i = 10*i.
module tb_memory_tile_reader;
    import tile_reader_pkg::*;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 18;
    localparam int DIM_W  = 8;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [DIM_W-1:0]  tile_w, tile_h, row_stride;
`ifdef TILE_READER_ZERO_PAD_EN
    logic [1:0]        pad;
`endif
    logic              busy, done;
    logic [ADDR_W-1:0] mem_read_addr;
    logic [DATA_W-1:0] mem_read_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid, out_ready, out_last;
    tile_state_e       fsm_state;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DATA_W:0]   exp_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [ADDR_W-1:0] got_addr_q[$];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        logic [31:0] v;
        v = 32'(a) * 32'd10;
        return v[DATA_W-1:0];
    endfunction

    always @(posedge clk) mem_read_data <= mem_word(mem_read_addr);

    memory_tile_reader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DIM_W  (DIM_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .tile_w        (tile_w),
        .tile_h        (tile_h),
        .row_stride    (row_stride),
`ifdef TILE_READER_ZERO_PAD_EN
        .pad           (pad),
`endif
        .busy          (busy),
        .done          (done),
        .mem_read_addr (mem_read_addr),
        .mem_read_data (mem_read_data),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .fsm_state     (fsm_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: the padded frame in raster order; interior pixel (r,c) reads
    // base + r*stride + c, border pixels are zero; last flag on the final position.
    task automatic build_model(input logic [ADDR_W-1:0] base, input int w, input int h,
                               input int stride, input int p);
        int          fw, fh;
        logic [31:0] a;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        bit          interior, last;
        exp_q.delete();
        exp_addr_q.delete();
        fw = (w == 0 || h == 0) ? 0 : w + 2 * p;
        fh = (w == 0 || h == 0) ? 0 : h + 2 * p;
        for (int r = 0; r < fh; r++) begin
            for (int c = 0; c < fw; c++) begin
                interior = (r >= p) && (r < p + h) && (c >= p) && (c < p + w);
                data = '0;
                if (interior) begin
                    a    = 32'(base) + 32'((r - p) * stride + (c - p));
                    addr = a[ADDR_W-1:0];
                    data = mem_word(addr);
                    exp_addr_q.push_back(addr);
                end
                last = (r == fh - 1) && (c == fw - 1);
                exp_q.push_back({last, data});
            end
        end
    endtask

    // driver + monitor for one tile; called at posedge+1
    task automatic run_tile(input string name, input logic [ADDR_W-1:0] base, input int w,
                            input int h, input int stride, input int p, input int ready_pct,
                            input int budget, output int first_valid, output int last_hs,
                            output int done_cyc, output bit busy_seen, output bit busy_at_done);
        int                done_cnt = 0;
        bit                credit_bad = 0, stable_bad = 0, prev_stall = 0, addr_ok = 1;
        logic [DATA_W:0]   prev_beat = '0;
        logic [ADDR_W-1:0] prev_addr, pa;
        first_valid = -1; last_hs = -1; done_cyc = -1; busy_seen = 0; busy_at_done = 0;
        build_model(base, w, h, stride, p);
        got_addr_q.delete();
        prev_addr = mem_read_addr;
        pa = prev_addr;
        foreach (exp_addr_q[i]) begin
            if (exp_addr_q[i] == pa) addr_ok = 0;
            pa = exp_addr_q[i];
        end
        base_addr  = base;
        tile_w     = DIM_W'(w);
        tile_h     = DIM_W'(h);
        row_stride = DIM_W'(stride);
`ifdef TILE_READER_ZERO_PAD_EN
        pad = 2'(p);
`endif
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        out_ready = ($urandom_range(99) < ready_pct);
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (mem_read_addr !== prev_addr) begin
                got_addr_q.push_back(mem_read_addr);
                prev_addr = mem_read_addr;
            end
            if (busy) busy_seen = 1;
            if (int'(dut.buf_count) + int'(dut.inflight_q) > 2) credit_bad = 1;
            if (prev_stall && (!out_valid || {out_last, out_data} !== prev_beat)) stable_bad = 1;
            if (out_valid && first_valid < 0) first_valid = n;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check({name, "_extra_beat"}, 32'({out_last, out_data}), 32'h7fffffff);
                else check({name, "_beat"}, 32'({out_last, out_data}), 32'(exp_q.pop_front()));
                if (out_last) last_hs = n;
            end
            prev_stall = out_valid && !out_ready;
            prev_beat  = {out_last, out_data};
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = n;
                    busy_at_done = busy;
                end
            end
            if (done_cyc >= 0 && n >= done_cyc + 3) break;
            @(posedge clk);
            #1 out_ready = ($urandom_range(99) < ready_pct);
        end
        @(posedge clk);
        #1;
        check({name, "_done_count"}, 32'(done_cnt), 32'd1);
        check({name, "_beats_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_credit"}, 32'(credit_bad), 32'd0);
        check({name, "_stable"}, 32'(stable_bad), 32'd0);
        if (addr_ok) begin
            check({name, "_addr_count"}, 32'(got_addr_q.size()), 32'(exp_addr_q.size()));
            foreach (exp_addr_q[i]) begin
                if (i < got_addr_q.size()) check({name, "_addr"}, 32'(got_addr_q[i]), 32'(exp_addr_q[i]));
            end
        end
    endtask

    initial begin
        int fv, lh, dc, hs, vcnt, dcnt;
        bit bs, bd;
        rst = 1'b1; start = 1'b0; base_addr = '0; tile_w = '0; tile_h = '0; row_stride = '0;
`ifdef TILE_READER_ZERO_PAD_EN
        pad = 2'd0;
`endif
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_addr", 32'(mem_read_addr), 32'd0);
        check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_tile("basic", 16'd100, 3, 2, 10, 0, 100, 60, fv, lh, dc, bs, bd);
        check("basic_first_valid", 32'(fv), 32'd3);
        check("basic_done_after_last", 32'(dc), 32'(lh + 1));
        check("basic_busy_seen", 32'(bs), 32'd1);
        check("basic_busy_at_done", 32'(bd), 32'd0);

        run_tile("backpressure", 16'd100, 3, 2, 10, 0, 40, 300, fv, lh, dc, bs, bd);
        check("bp_done_after_last", 32'(dc), 32'(lh + 1));

        run_tile("zero", 16'h0500, 0, 5, 10, 0, 100, 10, fv, lh, dc, bs, bd);
        check("zero_busy", 32'(bs), 32'd0);
        check("zero_no_valid", 32'(fv), 32'hffffffff);
        check("zero_done_soon", 32'(dc >= 1 && dc <= 2), 32'd1);

        run_tile("wrap", 16'hFFFE, 4, 1, 10, 0, 100, 60, fv, lh, dc, bs, bd);
        check("wrap_first_valid", 32'(fv), 32'd3);

        // abort an 8x8 tile just after its third beat
        base_addr = 16'h0300; tile_w = 8'd8; tile_h = 8'd8; row_stride = 8'd16;
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        hs = 0;
        for (int n = 0; n < 50 && hs < 3; n++) begin
            @(negedge clk);
            if (out_valid && out_ready) hs++;
        end
        check("abort_reached_beat3", 32'(hs), 32'd3);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_state", 32'(fsm_state), 32'(ST_IDLE));
        vcnt = 0; dcnt = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (out_valid) vcnt++;
            if (done || busy) dcnt++;
        end
        @(posedge clk);
        #1;
        check("abort_stale_beats", 32'(vcnt), 32'd0);
        check("abort_no_done", 32'(dcnt), 32'd0);
        run_tile("after_rst", 16'd0, 2, 1, 10, 0, 100, 40, fv, lh, dc, bs, bd);

`ifdef TILE_READER_ZERO_PAD_EN
        run_tile("pad", 16'h0200, 2, 1, 10, 1, 100, 80, fv, lh, dc, bs, bd);
        check("pad_done_after_last", 32'(dc), 32'(lh + 1));
`endif

        for (int t = 0; t < 6; t++) begin
            int p;
            p = 0;
`ifdef TILE_READER_ZERO_PAD_EN
            p = $urandom_range(3);
`endif
            run_tile("random", 16'($urandom), $urandom_range(6, 1), $urandom_range(4, 1),
                     $urandom_range(40), p, $urandom_range(100, 30), 1500, fv, lh, dc, bs, bd);
            check("random_done_after_last", 32'(dc), 32'(lh + 1));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
